// File: rtl/head_table_pipe_if.sv
// Lookup request, head result, head-table write and clear-control bundle
// of the head-table lookup stage.
interface head_table_pipe_if #(
    parameter int BUCKET_WIDTH = 10,
    parameter int PTR_WIDTH    = 10,
    parameter int PDATA_WIDTH  = 64
);
    logic [BUCKET_WIDTH-1:0] in_bucket_i;
    logic [PDATA_WIDTH-1:0]  in_pdata_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [PDATA_WIDTH-1:0]  out_pdata_o;
    logic [BUCKET_WIDTH-1:0] out_bucket_o;
    logic [PTR_WIDTH-1:0]    out_head_ptr_o;
    logic                    out_head_ptr_val_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic                    wr_en_i;
    logic [BUCKET_WIDTH-1:0] wr_addr_i;
    logic [PTR_WIDTH-1:0]    wr_ptr_i;
    logic                    wr_ptr_val_i;
    logic                    clear_run_i;
    logic                    clear_busy_o;
    logic                    clear_done_o;

    modport slave (
        input  in_bucket_i, in_pdata_i, in_valid_i, out_ready_i,
               wr_en_i, wr_addr_i, wr_ptr_i, wr_ptr_val_i, clear_run_i,
        output in_ready_o, out_pdata_o, out_bucket_o, out_head_ptr_o,
               out_head_ptr_val_o, out_valid_o, clear_busy_o, clear_done_o
    );

    modport master (
        output in_bucket_i, in_pdata_i, in_valid_i, out_ready_i,
               wr_en_i, wr_addr_i, wr_ptr_i, wr_ptr_val_i, clear_run_i,
        input  in_ready_o, out_pdata_o, out_bucket_o, out_head_ptr_o,
               out_head_ptr_val_o, out_valid_o, clear_busy_o, clear_done_o
    );
endinterface

// File: rtl/head_table_pipe.sv
// Hash-table head-pointer lookup: RAM read with write forwarding, stall-safe
// re-read, optional output register and a full-table clear engine.
module head_table_pipe #(
    parameter int BUCKET_WIDTH = 10,
    parameter int PTR_WIDTH    = 10,
    parameter int PDATA_WIDTH  = 64,
    parameter int OUT_REG      = 0
) (
    input logic              clk_i,
    input logic              rst_i,
    head_table_pipe_if.slave bus
);
    localparam int DEPTH = 1 << BUCKET_WIDTH;
    localparam int HW    = PTR_WIDTH + 1;

    logic [HW-1:0]           mem [DEPTH];
    logic [HW-1:0]           ram_q, fwd_data, s1_head, wdata;
    logic                    fwd_hit, we;
    logic [BUCKET_WIDTH-1:0] rd_addr, waddr, clr_cnt, s1_bucket;
    logic [PDATA_WIDTH-1:0]  s1_pdata;
    logic                    s1_vld, s1_adv, s1_take, accept, clr_busy;

    // The clear engine owns the write port while busy.
    always_comb begin
        we    = clr_busy | bus.wr_en_i;
        waddr = clr_busy ? clr_cnt : bus.wr_addr_i;
        wdata = clr_busy ? '0 : {bus.wr_ptr_i, bus.wr_ptr_val_i};
    end

    assign s1_adv         = !s1_vld || s1_take;
    assign bus.in_ready_o = s1_adv && !clr_busy;
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    // A held entry re-reads its bucket every cycle so stalls never go stale.
    assign rd_addr        = accept ? bus.in_bucket_i : s1_bucket;
    assign s1_head        = fwd_hit ? fwd_data : ram_q;

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= we && (waddr == rd_addr);
            fwd_data <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld    <= 1'b0;
            s1_bucket <= '0;
            s1_pdata  <= '0;
        end else if (s1_adv) begin
            s1_vld <= accept;
            if (accept) begin
                s1_bucket <= bus.in_bucket_i;
                s1_pdata  <= bus.in_pdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
        end else if (bus.clear_run_i) begin
            clr_busy <= 1'b1;
            clr_cnt  <= '0;
        end else if (clr_busy) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) clr_busy <= 1'b0;
        end
    end

    assign bus.clear_busy_o = clr_busy;
    assign bus.clear_done_o = clr_busy && (&clr_cnt);

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                    s2_vld, s2_load;
            logic [BUCKET_WIDTH-1:0] s2_bucket;
            logic [PDATA_WIDTH-1:0]  s2_pdata;
            logic [HW-1:0]           s2_head;

            assign s2_load = s1_vld && (!s2_vld || bus.out_ready_i);
            assign s1_take = !s2_vld || bus.out_ready_i;

            // S1's value lags writes by one cycle, so this cycle's write is
            // folded in on load and snooped while S2 holds.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s2_vld    <= 1'b0;
                    s2_bucket <= '0;
                    s2_pdata  <= '0;
                    s2_head   <= '0;
                end else if (s2_load) begin
                    s2_vld    <= 1'b1;
                    s2_bucket <= s1_bucket;
                    s2_pdata  <= s1_pdata;
                    s2_head   <= (we && waddr == s1_bucket) ? wdata : s1_head;
                end else begin
                    if (bus.out_ready_i) s2_vld <= 1'b0;
                    if (s2_vld && we && waddr == s2_bucket) s2_head <= wdata;
                end
            end

            assign bus.out_valid_o  = s2_vld;
            assign bus.out_bucket_o = s2_bucket;
            assign bus.out_pdata_o  = s2_pdata;
            assign {bus.out_head_ptr_o, bus.out_head_ptr_val_o} = s2_head;
        end else begin : g_direct
            assign s1_take          = bus.out_ready_i;
            assign bus.out_valid_o  = s1_vld;
            assign bus.out_bucket_o = s1_bucket;
            assign bus.out_pdata_o  = s1_pdata;
            assign {bus.out_head_ptr_o, bus.out_head_ptr_val_o} = s1_vld ? s1_head : '0;
        end
    endgenerate
endmodule
